// File: rtl/ann_weight_pkg.sv
// ann_weight_pkg
// Shared constants and types for the neuron weight-read path.
//   WEIGHT_DEPTH   : number of weight words held in one neuron's BRAM
//   WEIGHT_ADDR_W  : BRAM address width (2**WEIGHT_ADDR_W >= WEIGHT_DEPTH)
//   WEIGHT_DATA_W  : width of one weight word
//   weight_state_t : sequencer states of weight_stream_reader
//   weight_entry_t : one buffered word plus the address it came from and
//                    whether it is the final word of the stream
package ann_weight_pkg;

    localparam int WEIGHT_DEPTH  = 28;
    localparam int WEIGHT_ADDR_W = 5;
    localparam int WEIGHT_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } weight_state_t;

    typedef struct packed {
        logic [WEIGHT_DATA_W-1:0] data;
        logic [WEIGHT_ADDR_W-1:0] idx;
        logic                     last;
    } weight_entry_t;

endpackage

// File: rtl/weight_skid_fifo.sv
// weight_skid_fifo
// Two-entry synchronous FIFO that holds words read from the weight BRAM
// until the MAC datapath accepts them. Push and pop in the same cycle are
// allowed and leave the count unchanged. The head entry never moves while
// it is not popped, so a stalled consumer sees stable data.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, empties the FIFO
//   push       : write push_entry at the tail
//   push_entry : entry to store
//   pop        : remove the head entry (caller only pops when count != 0)
//   head       : entry at the head of the FIFO
//   count      : number of stored entries, 0..2
module weight_skid_fifo
    import ann_weight_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  weight_entry_t push_entry,
    input  logic          pop,
    output weight_entry_t head,
    output logic [1:0]    count
);

    weight_entry_t mem [2];
    logic          wr_sel;
    logic          rd_sel;

    // Storage is cleared on reset so the head reads as all zeros afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_sel] <= push_entry;
                wr_sel      <= ~wr_sel;
            end
            if (pop) begin
                rd_sel <= ~rd_sel;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_sel];

    // The reader's credit scheme must never let a word arrive with no room.
    push_into_full: assert property (@(posedge clk) disable iff (rst)
        !(push && count == 2'd2));

endmodule

// File: rtl/weight_stream_reader.sv
// weight_stream_reader
// Read-side sequencer for one neuron's weight BRAM. A START pulse streams
// every word, address 0 first, out on a valid/ready interface tagged with
// its source address and a last flag. Reads are issued only when the word
// they return is guaranteed a slot in the 2-entry output buffer, giving
// one word per cycle without backpressure and no lost words with it.
// Ports:
//   CLK       : clock; this block uses the rising edge, the BRAM the falling
//   RST       : synchronous active-high reset
//   START     : one-cycle request to stream all words, honoured only in IDLE
//   BUSY      : run in progress, up to and including the final handshake
//   DONE      : one-cycle pulse after the final handshake
//   BRAM_ADDR : registered read address
//   BRAM_EN   : registered read strobe, high only in read cycles
//   BRAM_WE   : tied low, this block never writes
//   BRAM_DI   : tied to zero
//   BRAM_DO   : BRAM read data
//   W_DATA    : weight word at the buffer head
//   W_IDX     : address the head word was read from
//   W_LAST    : head word is the final word of the stream
//   W_VALID   : head word valid
//   W_READY   : consumer accepts the head word when W_VALID is also high
module weight_stream_reader
    import ann_weight_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [WEIGHT_ADDR_W-1:0] BRAM_ADDR,
    output logic                     BRAM_EN,
    output logic                     BRAM_WE,
    output logic [WEIGHT_DATA_W-1:0] BRAM_DI,
    input  logic [WEIGHT_DATA_W-1:0] BRAM_DO,
    output logic [WEIGHT_DATA_W-1:0] W_DATA,
    output logic [WEIGHT_ADDR_W-1:0] W_IDX,
    output logic                     W_LAST,
    output logic                     W_VALID,
    input  logic                     W_READY
);

    localparam int                     PTR_W     = WEIGHT_ADDR_W + 1;
    localparam logic [PTR_W-1:0]         PTR_END   = PTR_W'(WEIGHT_DEPTH);
    localparam logic [WEIGHT_ADDR_W-1:0] LAST_ADDR = WEIGHT_ADDR_W'(WEIGHT_DEPTH - 1);

    weight_state_t            state_q;
    weight_state_t            state_d;
    logic [PTR_W-1:0]         rd_ptr_q;
    logic                     bram_en_q;
    logic [WEIGHT_ADDR_W-1:0] bram_addr_q;
    logic                     issue;
    logic                     pop;
    logic [2:0]               occupancy;
    logic [1:0]               fifo_count;
    weight_entry_t            push_entry;
    weight_entry_t            head;

    // A read whose strobe is high this cycle lands in the buffer at the end
    // of this cycle, so the strobe register doubles as the in-flight flag.
    // occupancy is the number of buffer slots spoken for after this edge.
    always_comb begin
        state_d   = state_q;
        issue     = 1'b0;
        pop       = W_VALID & W_READY;
        occupancy = 3'(fifo_count) + 3'(bram_en_q) - 3'(pop);
        case (state_q)
            IDLE: begin
                // rd_ptr is already zero here, so the START cycle itself
                // issues address 0 and the strobe appears one cycle later.
                if (START) begin
                    issue   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rd_ptr_q == PTR_END) begin
                    state_d = DRAIN;
                end else if (occupancy < 3'd2) begin
                    issue = 1'b1;
                end
            end
            DRAIN: begin
                // Leave as the final word is handed over, so FIN (and DONE)
                // falls in the cycle right after that handshake.
                if (occupancy == 3'd0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, read pointer and registered BRAM port drive.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            bram_en_q <= issue;
            if (issue) begin
                bram_addr_q <= rd_ptr_q[WEIGHT_ADDR_W-1:0];
                rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
            end else if (state_q == FIN) begin
                rd_ptr_q <= '0;
            end
        end
    end

    assign push_entry.data = BRAM_DO;
    assign push_entry.idx  = bram_addr_q;
    assign push_entry.last = (bram_addr_q == LAST_ADDR);

    weight_skid_fifo u_fifo (
        .clk        (CLK),
        .rst        (RST),
        .push       (bram_en_q),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count)
    );

    assign W_VALID   = (fifo_count != 2'd0);
    assign W_DATA    = head.data;
    assign W_IDX     = head.idx;
    assign W_LAST    = head.last;
    assign BUSY      = (state_q == RUN) || (state_q == DRAIN);
    assign DONE      = (state_q == FIN);
    assign BRAM_EN   = bram_en_q;
    assign BRAM_ADDR = bram_addr_q;
    assign BRAM_WE   = 1'b0;
    assign BRAM_DI   = '0;

endmodule

// File: tb/tb_weight_stream_reader.sv
// tb_weight_stream_reader
// Directed bench for weight_stream_reader with a behavioural falling-edge
// BRAM preloaded with a known pattern. Inputs are driven 1 time unit after
// the rising edge and outputs are sampled 1 unit later, so "cycle n" is the
// interval following the n-th rising edge after START.
module tb_weight_stream_reader;
    import ann_weight_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        BUSY;
    logic        DONE;
    logic [4:0]  BRAM_ADDR;
    logic        BRAM_EN;
    logic        BRAM_WE;
    logic [15:0] BRAM_DI;
    logic [15:0] BRAM_DO = '0;
    logic [15:0] W_DATA;
    logic [4:0]  W_IDX;
    logic        W_LAST;
    logic        W_VALID;
    logic        W_READY;

    logic [15:0] bram_mem [28];
    int          vectors     = 0;
    int          miscompares = 0;
    int          en_total    = 0;
    logic        we_seen     = 1'b0;
    logic        addr_bad    = 1'b0;

    weight_stream_reader dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .BRAM_ADDR (BRAM_ADDR),
        .BRAM_EN   (BRAM_EN),
        .BRAM_WE   (BRAM_WE),
        .BRAM_DI   (BRAM_DI),
        .BRAM_DO   (BRAM_DO),
        .W_DATA    (W_DATA),
        .W_IDX     (W_IDX),
        .W_LAST    (W_LAST),
        .W_VALID   (W_VALID),
        .W_READY   (W_READY)
    );

    always #5 CLK = ~CLK;

    // Word i of the BRAM file is 0x1000 + i*0x0103 (word 0 = 0x1000,
    // word 27 = 0x2B51).
    function automatic logic [15:0] weight_model(input int i);
        return 16'h1000 + 16'(i) * 16'h0103;
    endfunction

    initial begin
        for (int i = 0; i < 28; i++) bram_mem[i] = weight_model(i);
    end

    // Falling-edge BRAM: DO only changes on an enabled read.
    always @(negedge CLK) begin
        if (BRAM_EN === 1'b1) begin
            en_total = en_total + 1;
            if (BRAM_ADDR > 5'd27) addr_bad = 1'b1;
            else BRAM_DO = bram_mem[BRAM_ADDR];
        end
        if (BRAM_WE !== 1'b0 || BRAM_DI !== 16'h0) we_seen = 1'b1;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic start, input logic ready, input logic rst);
        @(posedge CLK);
        #1;
        START   = start;
        W_READY = ready;
        RST     = rst;
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_busy"},   32'(BUSY),      32'd0);
        check_output({tag, "_done"},   32'(DONE),      32'd0);
        check_output({tag, "_en"},     32'(BRAM_EN),   32'd0);
        check_output({tag, "_addr"},   32'(BRAM_ADDR), 32'd0);
        check_output({tag, "_valid"},  32'(W_VALID),   32'd0);
        check_output({tag, "_data"},   32'(W_DATA),    32'd0);
        check_output({tag, "_idx"},    32'(W_IDX),     32'd0);
        check_output({tag, "_last"},   32'(W_LAST),    32'd0);
    endtask

    // Runs one stream whose START was applied in cycle 0, consuming with
    // the given ready pattern (0: always ready, 1: stalled in cycles 2..20,
    // 2: random) and scoreboarding every handshake against the BRAM file.
    task automatic stream_and_check(input int mode, input bit extra_starts,
                                    input int en_base, output int done_cycle);
        int          exp_idx;
        bit          prev_stall;
        logic [21:0] held;
        logic        rdy;
        logic        stt;
        exp_idx    = 0;
        prev_stall = 1'b0;
        held       = '0;
        done_cycle = -1;
        for (int c = 1; c <= 600; c++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = !(c >= 2 && c <= 20);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            stt = extra_starts && (c == 5 || c == 15 || c == 30);
            apply_stimulus(stt, rdy, 1'b0);
            if (c == 1) begin
                check_output("first_en",    32'(BRAM_EN),   32'd1);
                check_output("first_addr",  32'(BRAM_ADDR), 32'd0);
                check_output("first_busy",  32'(BUSY),      32'd1);
                check_output("first_valid", 32'(W_VALID),   32'd0);
            end
            if (prev_stall)
                check_output("stall_hold", 32'({W_VALID, W_DATA, W_IDX, W_LAST}), 32'({1'b1, held}));
            if (mode == 0) begin
                check_output("run_busy",  32'(BUSY),    32'(c <= 29));
                check_output("run_valid", 32'(W_VALID), 32'(c >= 2 && c <= 29));
            end
            if (mode == 1 && c == 20) begin
                check_output("stall_reads", 32'(en_total - en_base), 32'd2);
                check_output("stall_idx",   32'(W_IDX),             32'd0);
            end
            if (W_VALID && W_READY) begin
                check_output("w_idx",  32'(W_IDX),  32'(exp_idx));
                check_output("w_data", 32'(W_DATA), 32'(weight_model(exp_idx)));
                check_output("w_last", 32'(W_LAST), 32'(exp_idx == 27));
                exp_idx++;
            end
            prev_stall = W_VALID && !W_READY;
            held       = {W_DATA, W_IDX, W_LAST};
            if (DONE) begin
                done_cycle = c;
                break;
            end
        end
        check_output("done_seen",   32'(done_cycle > 0), 32'd1);
        check_output("words_total", 32'(exp_idx),        32'd28);
    endtask

    initial begin
        int en_base;
        int done_cycle;
        RST     = 1'b1;
        START   = 1'b0;
        W_READY = 1'b0;

        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_reset_values("por");

        $display("[TB] free run");
        en_base = en_total;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        check_output("idle_busy", 32'(BUSY), 32'd0);
        stream_and_check(0, 1'b0, en_base, done_cycle);
        check_output("free_done_cycle", 32'(done_cycle),          32'd30);
        check_output("free_en_cycles",  32'(en_total - en_base),  32'd28);

        $display("[TB] backpressure");
        en_base = en_total;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        stream_and_check(1, 1'b0, en_base, done_cycle);

        $display("[TB] random ready");
        for (int r = 0; r < 20; r++) begin
            en_base = en_total;
            apply_stimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            stream_and_check(2, 1'b0, en_base, done_cycle);
        end
        check_output("we_or_di_nonzero", 32'(we_seen),  32'd0);
        check_output("addr_out_of_range", 32'(addr_bad), 32'd0);

        $display("[TB] extra start pulses");
        en_base = en_total;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        stream_and_check(0, 1'b1, en_base, done_cycle);
        check_output("extra_done_cycle", 32'(done_cycle), 32'd30);
        apply_stimulus(1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("restart_en",   32'(BRAM_EN),   32'd1);
        check_output("restart_addr", 32'(BRAM_ADDR), 32'd0);
        check_output("restart_busy", 32'(BUSY),      32'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("restart_idx",  32'(W_IDX),  32'd0);
        check_output("restart_data", 32'(W_DATA), 32'(weight_model(0)));

        $display("[TB] mid-run reset");
        for (int c = 3; c <= 9; c++) apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        check_output("inflight_at_reset", 32'(BRAM_EN), 32'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_reset_values("midrst");
        en_base = en_total;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        stream_and_check(0, 1'b0, en_base, done_cycle);
        check_output("post_reset_done_cycle", 32'(done_cycle), 32'd30);

        $display("[TB] start with reset");
        apply_stimulus(1'b1, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("strst_busy",  32'(BUSY),    32'd0);
        check_output("strst_en",    32'(BRAM_EN), 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("strst_busy2", 32'(BUSY),    32'd0);
        check_output("strst_valid", 32'(W_VALID), 32'd0);
        check_output("strst_en2",   32'(BRAM_EN), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
